// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BRK    = 3'd5;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Rounded to the nearest clock so the bit period error stays below half a clock.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; reset value is a parameter.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the old values on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 (or 8-bit + parity when UART_RX_PARITY_EN is defined), mid-bit sampling,
// one-byte holding register with ready / framing-error / overrun flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter bit PAR_ODD      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 ferr,
    output logic                 ovr,
`ifdef UART_RX_PARITY_EN
    output logic                 perr,
`endif
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 w_rxs;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_stop;
    logic                 r_commit;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rdy;
    logic                 r_ferr;
    logic                 r_ovr;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_perr;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_stop   <= 1'b1;
            r_commit <= 1'b0;
            r_data   <= '0;
            r_rdy    <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par    <= 1'b0;
            r_perr   <= 1'b0;
`endif
        end else begin
            r_commit <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rxs;
                        r_idx          <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_par   <= w_rxs;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt    <= '0;
                        r_stop   <= w_rxs;
                        r_commit <= 1'b1;
                        r_state  <= w_rxs ? ST_IDLE : ST_BRK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // A held-low line must rise before another start bit is accepted.
                ST_BRK: begin
                    if (w_rxs) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Holding register: a commit beats a simultaneous read.
            if (r_commit) begin
                if (!r_rdy || rd) begin
                    r_data <= r_shift;
                    r_rdy  <= 1'b1;
                    r_ferr <= ~r_stop;
                    r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    r_perr <= r_par ^ (^r_shift) ^ PAR_ODD;
`endif
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (rd && r_rdy) begin
                r_rdy  <= 1'b0;
                r_ferr <= 1'b0;
                r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_perr <= 1'b0;
`endif
            end
        end
    end

    assign rx_data = r_data;
    assign rx_rdy  = r_rdy;
    assign ferr    = r_ferr;
    assign ovr     = r_ovr;
    assign busy    = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign perr    = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at 16 clocks per bit; define UART_RX_PARITY_EN for the parity build.
module tb_uart_rx_core;

    localparam int CPB     = 16;
    localparam bit PAR_ODD = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       ferr;
    logic       ovr;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .PAR_ODD(PAR_ODD)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rd      (rd),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .ferr    (ferr),
        .ovr     (ovr),
`ifdef UART_RX_PARITY_EN
        .perr    (perr),
`endif
        .busy    (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit, data LSB first, and the parity bit in the parity build.
    task automatic send_head(input logic [7:0] d, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) $display("parity input unknown");
`endif
    endtask

    // Drives the stop bit; first_rdy is the first negedge (1-based) after the stop edge with rx_rdy high.
    task automatic send_stop(input logic stop, input int rd_at, output int first_rdy);
        first_rdy = 0;
        rx = stop;
        for (int k = 1; k <= CPB; k++) begin
            @(negedge clk);
            rd = (k == rd_at);
            if (rx_rdy && first_rdy == 0) first_rdy = k;
        end
        rd = 1'b0;
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        int fr;
        send_head(d, (^d) ^ PAR_ODD);
        send_stop(stop, 0, fr);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  fr;
        bit  busy_seen;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h81, stop: 1'b0, exp_data: 8'h81, exp_ferr: 1'b1};
        vecs[4] = '{data: 8'h6E, stop: 1'b1, exp_data: 8'h6E, exp_ferr: 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_rdy", rx_rdy, 0);
        check("reset ferr", ferr, 0);
        check("reset ovr", ovr, 0);
        check("reset busy", busy, 0);

        // Single frames: stop-edge-to-ready latency, held contents, then read.
        for (int v = 0; v < 5; v++) begin
            send_head(vecs[v].data, (^vecs[v].data) ^ PAR_ODD);
            send_stop(vecs[v].stop, 0, fr);
            check($sformatf("vec%0d latency", v), fr, 12);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d busy", v), busy, 0);
            check($sformatf("vec%0d rx_rdy", v), rx_rdy, 1);
            check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_data);
            check($sformatf("vec%0d ferr", v), ferr, vecs[v].exp_ferr);
            check($sformatf("vec%0d ovr", v), ovr, 0);
`ifdef UART_RX_PARITY_EN
            check($sformatf("vec%0d perr", v), perr, 0);
`endif
            pulse_rd();
            check($sformatf("vec%0d rd rx_rdy", v), rx_rdy, 0);
            check($sformatf("vec%0d rd ferr", v), ferr, 0);
        end

        // Short low glitch is rejected as a false start.
        busy_seen = 1'b0;
        rx = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 5) rx = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        check("glitch busy pulse", busy_seen, 1);
        check("glitch busy end", busy, 0);
        check("glitch rx_rdy", rx_rdy, 0);

        // Break: stop low, line held low five bit times.
        send_head(8'h3C, (^8'h3C) ^ PAR_ODD);
        rx = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        check("break rx_data", rx_data, 8'h3C);
        check("break ferr", ferr, 1);
        check("break rx_rdy", rx_rdy, 1);
        check("break busy", busy, 1);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("break release busy", busy, 0);
        check("break no second byte", ovr, 0);
        check("break rx_data kept", rx_data, 8'h3C);
        pulse_rd();

        // Back-to-back frames without a read: second byte discarded.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check("overrun rx_data", rx_data, 8'h11);
        check("overrun ovr", ovr, 1);
        check("overrun rx_rdy", rx_rdy, 1);
        pulse_rd();
        check("overrun rd rx_rdy", rx_rdy, 0);
        check("overrun rd ovr", ovr, 0);

        // Read on the commit cycle while an overrun is pending: the new byte wins.
        send_frame(8'h44, 1'b1);
        send_frame(8'h33, 1'b1);
        repeat (2) @(negedge clk);
        check("pre-commit-rd ovr", ovr, 1);
        check("pre-commit-rd rx_data", rx_data, 8'h44);
        send_head(8'h55, (^8'h55) ^ PAR_ODD);
        send_stop(1'b1, 11, fr);
        check("commit-rd rx_data", rx_data, 8'h55);
        check("commit-rd rx_rdy", rx_rdy, 1);
        check("commit-rd ovr", ovr, 0);
        pulse_rd();

`ifdef UART_RX_PARITY_EN
        send_head(8'h07, 1'b0);
        send_stop(1'b1, 0, fr);
        repeat (2) @(negedge clk);
        check("parity bad perr", perr, 1);
        check("parity bad rx_data", rx_data, 8'h07);
        pulse_rd();
        check("parity rd perr", perr, 0);
        send_head(8'h07, 1'b1);
        send_stop(1'b1, 0, fr);
        repeat (2) @(negedge clk);
        check("parity good perr", perr, 0);
        check("parity good rx_rdy", rx_rdy, 1);
        pulse_rd();
`endif

        // Reset in the middle of DATA while a byte is held.
        send_frame(8'h9A, 1'b0);
        repeat (4) @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset rx_data", rx_data, 8'h00);
        check("midreset rx_rdy", rx_rdy, 0);
        check("midreset ferr", ferr, 0);
        check("midreset ovr", ovr, 0);
        check("midreset busy", busy, 0);
        repeat (200) @(negedge clk);
        check("midreset no byte", rx_rdy, 0);
        send_head(8'hF0, (^8'hF0) ^ PAR_ODD);
        send_stop(1'b1, 0, fr);
        check("after reset latency", fr, 12);
        check("after reset rx_data", rx_data, 8'hF0);
        check("after reset ferr", ferr, 0);
        check("after reset ovr", ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
